// File: rtl/tetris_vga_render.sv
// ============================================================================
//  Module   : tetris_vga_render
//  Purpose  : Display-side reader of the Tetris playfield. Generates VGA
//             timing (1024x768@60 Hz at 65 MHz by default), snapshots the
//             board and falling-piece cells once per frame, and renders
//             border, grid, locked cells and falling piece through a
//             3-stage pixel pipeline.
//  Ports    : Clk          - pixel clock
//             Rst          - synchronous active-high reset
//             Game[251:0]  - board, bit row*14+col
//             Cur_1..Cur_4 - falling-piece cell indices (>251 = no cell)
//             Hsync, Vsync - active-low syncs
//             De           - visible-area data enable
//             Rgb[7:0]     - pixel colour {R[2:0],G[2:0],B[1:0]}
//             Frame_Start  - one-cycle pulse aligned with the snapshot
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tetris_vga_render #(
  parameter int         BOARD_X0  = 288,
  parameter int         BOARD_Y0  = 96,
  parameter int         BORDER_W  = 4,
  parameter logic [7:0] C_BG      = 8'h00,
  parameter logic [7:0] C_GRID    = 8'h25,
  parameter logic [7:0] C_LOCK    = 8'hDB,
  parameter logic [7:0] C_PIECE   = 8'hFC,
  parameter logic [7:0] C_BORDER  = 8'hFF,
  parameter int         H_VISIBLE = 1024,
  parameter int         H_FRONT   = 24,
  parameter int         H_SYNC    = 136,
  parameter int         H_BACK    = 160,
  parameter int         V_VISIBLE = 768,
  parameter int         V_FRONT   = 3,
  parameter int         V_SYNC    = 6,
  parameter int         V_BACK    = 29
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [251:0] Game,
  input  logic [7:0]   Cur_1,
  input  logic [7:0]   Cur_2,
  input  logic [7:0]   Cur_3,
  input  logic [7:0]   Cur_4,
  output logic         Hsync,
  output logic         Vsync,
  output logic         De,
  output logic [7:0]   Rgb,
  output logic         Frame_Start
);

  localparam int c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_HS_START = H_VISIBLE + H_FRONT;
  localparam int c_VS_START = V_VISIBLE + V_FRONT;
  localparam int c_BOARD_W  = 448;  // 14 columns x 32 px
  localparam int c_BOARD_H  = 576;  // 18 rows x 32 px

  // ---------------------------------------------------------------- counters
  logic [10:0] r_h_cnt, r_v_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == 11'(c_H_TOTAL - 1)) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == 11'(c_V_TOTAL - 1)) ? '0 : r_v_cnt + 11'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  // ---------------------------------------------------------------- snapshot
  // Taken at the first blank line so the whole visible frame sees one state.
  logic            w_snap;
  logic [251:0]    r_sh_game;
  logic [3:0][7:0] r_sh_cur;

  assign w_snap = (r_h_cnt == 11'd0) && (r_v_cnt == 11'(V_VISIBLE));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sh_game <= '0;
      r_sh_cur  <= {4{8'hFF}};
    end else if (w_snap) begin
      r_sh_game <= Game;
      r_sh_cur  <= {Cur_4, Cur_3, Cur_2, Cur_1};
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [10:0] w_dx, w_dy;
  logic        w_in_board, w_in_frame, w_de, w_hs, w_vs;

  assign w_dx       = r_h_cnt - 11'(BOARD_X0);
  assign w_dy       = r_v_cnt - 11'(BOARD_Y0);
  assign w_in_board = (w_dx < 11'(c_BOARD_W)) && (w_dy < 11'(c_BOARD_H));
  // Frame extent compared on un-offset counters; the extra bit keeps
  // h + BORDER_W from wrapping near the right edge of the counter range.
  assign w_in_frame = (({1'b0, r_h_cnt} + 12'(BORDER_W)) >= 12'(BOARD_X0)) &&
                      (r_h_cnt < 11'(BOARD_X0 + c_BOARD_W + BORDER_W)) &&
                      (({1'b0, r_v_cnt} + 12'(BORDER_W)) >= 12'(BOARD_Y0)) &&
                      (r_v_cnt < 11'(BOARD_Y0 + c_BOARD_H + BORDER_W));
  assign w_de = (r_h_cnt < 11'(H_VISIBLE)) && (r_v_cnt < 11'(V_VISIBLE));
  assign w_hs = !((r_h_cnt >= 11'(c_HS_START)) && (r_h_cnt < 11'(c_HS_START + H_SYNC)));
  assign w_vs = !((r_v_cnt >= 11'(c_VS_START)) && (r_v_cnt < 11'(c_VS_START + V_SYNC)));

  logic       r1_de, r1_hs, r1_vs, r1_fs, r1_in_board, r1_in_border, r1_gap;
  logic [3:0] r1_col;
  logic [4:0] r1_row;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r1_de        <= 1'b0;
      r1_hs        <= 1'b1;
      r1_vs        <= 1'b1;
      r1_fs        <= 1'b0;
      r1_in_board  <= 1'b0;
      r1_in_border <= 1'b0;
      r1_gap       <= 1'b0;
      r1_col       <= '0;
      r1_row       <= '0;
    end else begin
      r1_de        <= w_de;
      r1_hs        <= w_hs;
      r1_vs        <= w_vs;
      r1_fs        <= w_snap;
      r1_in_board  <= w_in_board;
      r1_in_border <= w_in_frame && !w_in_board;
      r1_gap       <= (w_dx[4:0] == 5'd0) || (w_dy[4:0] == 5'd0);
      r1_col       <= w_dx[8:5];
      r1_row       <= w_dy[9:5];
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [7:0] w_idx;
  logic       w_lock, w_piece;

  // Outside the board the index can exceed 251; the guard keeps the board
  // select in range and the result is masked by in_board later anyway.
  assign w_idx  = ({3'b000, r1_row} * 8'd14) + {4'b0000, r1_col};
  assign w_lock = (w_idx <= 8'd251) ? r_sh_game[w_idx] : 1'b0;

  always_comb begin
    w_piece = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((r_sh_cur[i] <= 8'd251) && (r_sh_cur[i] == w_idx)) w_piece = 1'b1;
    end
  end

  logic r2_de, r2_hs, r2_vs, r2_fs, r2_in_board, r2_in_border, r2_gap;
  logic r2_lock, r2_piece;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r2_de        <= 1'b0;
      r2_hs        <= 1'b1;
      r2_vs        <= 1'b1;
      r2_fs        <= 1'b0;
      r2_in_board  <= 1'b0;
      r2_in_border <= 1'b0;
      r2_gap       <= 1'b0;
      r2_lock      <= 1'b0;
      r2_piece     <= 1'b0;
    end else begin
      r2_de        <= r1_de;
      r2_hs        <= r1_hs;
      r2_vs        <= r1_vs;
      r2_fs        <= r1_fs;
      r2_in_board  <= r1_in_board;
      r2_in_border <= r1_in_border;
      r2_gap       <= r1_gap;
      r2_lock      <= w_lock;
      r2_piece     <= w_piece;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [7:0] w_rgb;

  always_comb begin
    w_rgb = 8'h00;
    if (!r2_de)             w_rgb = 8'h00;
    else if (r2_in_border)  w_rgb = C_BORDER;
    else if (!r2_in_board)  w_rgb = C_BG;
    else if (r2_piece)      w_rgb = r2_gap ? C_BG : C_PIECE;
    else if (r2_lock)       w_rgb = r2_gap ? C_BG : C_LOCK;
    else                    w_rgb = r2_gap ? C_GRID : C_BG;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Hsync       <= 1'b1;
      Vsync       <= 1'b1;
      De          <= 1'b0;
      Rgb         <= 8'h00;
      Frame_Start <= 1'b0;
    end else begin
      Hsync       <= r2_hs;
      Vsync       <= r2_vs;
      De          <= r2_de;
      Rgb         <= w_rgb;
      Frame_Start <= r2_fs;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tetris_vga_render.sv
// ============================================================================
//  Module   : tb_tetris_vga_render
//  Purpose  : Self-checking bench for tetris_vga_render. Uses a reduced
//             timing/geometry so several frames fit in a short run; a
//             pixel-level reference model feeds a scoreboard queue that is
//             compared with the DUT outputs every cycle, plus directed pixel,
//             sync-width and pulse-count checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tetris_vga_render;

  localparam int c_X0 = 4,   c_Y0 = 4,  c_BW = 4;
  localparam int c_HV = 456, c_HF = 2,  c_HS = 4, c_HB = 2;
  localparam int c_VV = 68,  c_VF = 1,  c_VS = 2, c_VB = 1;
  localparam int c_HT = c_HV + c_HF + c_HS + c_HB;
  localparam int c_VT = c_VV + c_VF + c_VS + c_VB;

  logic         clk = 1'b0;
  logic         rst;
  logic [251:0] game;
  logic [7:0]   cur_1, cur_2, cur_3, cur_4;
  logic         hsync, vsync, de, frame_start;
  logic [7:0]   rgb;

  always #5 clk = ~clk;

  tetris_vga_render #(
    .BOARD_X0(c_X0), .BOARD_Y0(c_Y0), .BORDER_W(c_BW),
    .H_VISIBLE(c_HV), .H_FRONT(c_HF), .H_SYNC(c_HS), .H_BACK(c_HB),
    .V_VISIBLE(c_VV), .V_FRONT(c_VF), .V_SYNC(c_VS), .V_BACK(c_VB)
  ) u_dut (
    .Clk(clk), .Rst(rst), .Game(game),
    .Cur_1(cur_1), .Cur_2(cur_2), .Cur_3(cur_3), .Cur_4(cur_4),
    .Hsync(hsync), .Vsync(vsync), .De(de), .Rgb(rgb), .Frame_Start(frame_start)
  );

  typedef struct {
    int         h;
    int         v;
    logic [11:0] o;   // {hs, vs, de, fs, rgb}
  } exp_t;

  exp_t         sb[$];
  int           n_total = 0, n_bad = 0;
  int           m_h = 0, m_v = 0;
  logic [251:0] m_game = '0;
  logic [7:0]   m_cur[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
  int           o_h = -1, o_v = -1;
  int           hs_run = 0, vs_run = 0, de_run = 0, fc_cnt = 0;
  int           fs_got = 0, fs_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference pixel model written directly from the screen geometry.
  function automatic logic [11:0] model(input int h, input int v);
    logic hs, vs, dv, fs, inb, inf, gap, piece;
    logic [7:0] c;
    int col, row, idx;
    dv = (h < c_HV) && (v < c_VV);
    hs = !((h >= c_HV + c_HF) && (h < c_HV + c_HF + c_HS));
    vs = !((v >= c_VV + c_VF) && (v < c_VV + c_VF + c_VS));
    fs = (h == 0) && (v == c_VV);
    c  = 8'h00;
    if (dv) begin
      inb = (h >= c_X0) && (h < c_X0 + 448) && (v >= c_Y0) && (v < c_Y0 + 576);
      inf = (h >= c_X0 - c_BW) && (h < c_X0 + 448 + c_BW) &&
            (v >= c_Y0 - c_BW) && (v < c_Y0 + 576 + c_BW);
      if (!inb && inf)  c = 8'hFF;
      else if (!inb)    c = 8'h00;
      else begin
        col   = (h - c_X0) / 32;
        row   = (v - c_Y0) / 32;
        gap   = ((h - c_X0) % 32 == 0) || ((v - c_Y0) % 32 == 0);
        idx   = row * 14 + col;
        piece = 1'b0;
        for (int k = 0; k < 4; k++)
          if ((int'(m_cur[k]) <= 251) && (int'(m_cur[k]) == idx)) piece = 1'b1;
        if (piece)             c = gap ? 8'h00 : 8'hFC;
        else if (m_game[idx])  c = gap ? 8'h00 : 8'hDB;
        else                   c = gap ? 8'h25 : 8'h00;
      end
    end
    return {hs, vs, dv, fs, c};
  endfunction

  // Called at a falling edge with the inputs for the next rising edge set.
  task automatic cycle();
    exp_t e;
    if (rst) begin
      sb.delete();
      e.h = -1; e.v = -1; e.o = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      repeat (3) sb.push_back(e);
      m_h = 0; m_v = 0; m_game = '0;
      m_cur = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    end else begin
      e.h = m_h; e.v = m_v; e.o = model(m_h, m_v);
      sb.push_back(e);
      if (m_h == 0 && m_v == c_VV) begin
        m_game = game;
        m_cur  = '{cur_1, cur_2, cur_3, cur_4};
      end
      if (m_h == c_HT - 1) begin
        m_h = 0;
        m_v = (m_v == c_VT - 1) ? 0 : m_v + 1;
      end else m_h++;
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      o_h = e.h; o_v = e.v;
      check($sformatf("pix(%0d,%0d)", e.h, e.v),
            {20'd0, hsync, vsync, de, frame_start, rgb}, {20'd0, e.o});
      if (e.o[8]) fs_exp++;
      if (frame_start === 1'b1) fs_got++;
      if (rgb === 8'hFC) fc_cnt++;
      if (hsync === 1'b0) hs_run++;
      else begin
        if (hs_run > 0) check("hsync_low_len", hs_run, c_HS);
        hs_run = 0;
      end
      if (vsync === 1'b0) vs_run++;
      else begin
        if (vs_run > 0) check("vsync_low_len", vs_run, c_VS * c_HT);
        vs_run = 0;
      end
      if (de === 1'b1) de_run++;
      else begin
        if (de_run > 0) check("de_high_len", de_run, c_HV);
        de_run = 0;
      end
    end
  endtask

  // Advance until the output shows the pixel for counter (h,v), bounded.
  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(o_h == h && o_v == v) && n < 40000);
    check($sformatf("reach(%0d,%0d)", h, v), {o_h[15:0], o_v[15:0]}, {h[15:0], v[15:0]});
  endtask

  initial begin
    rst = 1'b1; game = '0;
    cur_1 = 8'hFF; cur_2 = 8'hFF; cur_3 = 8'hFF; cur_4 = 8'hFF;
    repeat (5) begin
      cycle();
      check("rst_outputs", {hsync, vsync, de, rgb}, {1'b1, 1'b1, 1'b0, 8'h00});
    end
    rst = 1'b0;

    // Board for the first snapshot: locks at 0, 15, 16; pieces at 15, 13;
    // Cur_2 out of range.
    game[0] = 1'b1; game[15] = 1'b1; game[16] = 1'b1;
    cur_1 = 8'd15; cur_2 = 8'd252; cur_3 = 8'd13; cur_4 = 8'hFF;
    run_to(0, c_VV);
    fc_cnt = 0;

    run_to(100, 1);  check("border_top",   rgb, 8'hFF);
    run_to(4, 5);    check("lock0_gap",    rgb, 8'h00);
    run_to(5, 5);    check("lock0",        rgb, 8'hDB);
    run_to(36, 5);   check("grid_col1",    rgb, 8'h25);
    run_to(37, 5);   check("bg_col1",      rgb, 8'h00);
    run_to(2, 9);    check("border_left",  rgb, 8'hFF);
    run_to(430, 14); check("piece13",      rgb, 8'hFC);
    run_to(453, 20); check("border_right", rgb, 8'hFF);

    // Mid-frame input change must not show until the next snapshot.
    run_to(0, 21);
    game = '0; game[2] = 1'b1; cur_1 = 8'hFF;
    run_to(5, 30);   check("coh_old_lock", rgb, 8'hDB);
    run_to(73, 30);  check("coh_new_dark", rgb, 8'h00);
    run_to(41, 41);  check("piece_over_lock", rgb, 8'hFC);
    run_to(78, 46);  check("lock16",       rgb, 8'hDB);
    run_to(0, c_VV);
    check("piece_px_count", fc_cnt, 2 * 31 * 31);

    run_to(5, 10);   check("coh_cleared",  rgb, 8'h00);
    run_to(73, 10);  check("coh_new_lit",  rgb, 8'hDB);

    // Mid-frame reset: restart timing and clear the shadow board.
    run_to(c_HT - 1, 11);
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    run_to(5, 5);    check("post_rst_empty", rgb, 8'h00);
    run_to(36, 5);   check("post_rst_grid",  rgb, 8'h25);
    run_to(430, 14); check("post_rst_nopiece", rgb, 8'h00);
    run_to(0, 16);

    check("frame_start_count", fs_got, fs_exp);
    check("frame_start_seen",  fs_got, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
